dcache: RTL

Direct-mapped, write-through, no-write-allocate data cache between the memory stage's load/store port and the multi-cycle backing data memory. Load hits return data in the same cycle. Load misses refill a full line over a req/ack handshake while holding the pipeline through `Stall_o`. Stores are written through to memory, and also update the line if it hits. Sign/zero extension and byte-lane alignment stay in the memory stage; this block only sees word addresses plus byte enables.

---
 rtl/dcache.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill
// over a req/ack handshake to a multi-cycle backing memory.
module dcache #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Req_i,
    input  logic                  WE_i,
    input  logic [ADDR_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0] WData_i,
    input  logic [3:0]            ByteEn_i,
    output logic [DATA_WIDTH-1:0] RData_o,
    output logic                  Stall_o,
    output logic                  MemReq_o,
    output logic                  MemWE_o,
    output logic [ADDR_WIDTH-1:0] MemAddr_o,
    output logic [DATA_WIDTH-1:0] MemWData_o,
    output logic [3:0]            MemByteEn_o,
    input  logic                  MemAck_i,
    input  logic [DATA_WIDTH-1:0] MemRData_i
);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int SET_W   = $clog2(SETS);
    localparam int TAG_LSB = SET_W + OFF_W + 2;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam int LANE_W  = DATA_WIDTH / 4;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t state, state_next;

    logic [OFF_W-1:0]      cnt;
    logic [OFF_W-1:0]      word_idx;
    logic [SET_W-1:0]      set_idx;
    logic [TAG_W-1:0]      tag_in;
    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tags  [SETS];
    logic [DATA_WIDTH-1:0] lines [SETS][WORDS_PER_LINE];
    logic                  hit;
    logic                  last_word;
    logic                  refill_ack;
    logic                  write_ack;
    logic [1:0]            unused_offset;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*LANE_W +: LANE_W] = new_word[b*LANE_W +: LANE_W];
        end
        return res;
    endfunction

    assign unused_offset = Addr_i[1:0];
    assign word_idx      = Addr_i[OFF_W+1:2];
    assign set_idx       = Addr_i[TAG_LSB-1:OFF_W+2];
    assign tag_in        = Addr_i[ADDR_WIDTH-1:TAG_LSB];
    assign hit           = valid[set_idx] && (tags[set_idx] == tag_in);
    assign last_word     = (cnt == OFF_W'(WORDS_PER_LINE - 1));
    assign refill_ack    = (state == REFILL) && MemAck_i;
    assign write_ack     = (state == WRITE) && MemAck_i;

    // Control state: FSM, refill counter and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (refill_ack) begin
                cnt <= cnt + 1'b1;
            end
            if (refill_ack && last_word) valid[set_idx] <= 1'b1;
        end
    end

    // Tags and line data are not reset; valid bits alone guard them
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (refill_ack) begin
                lines[set_idx][cnt] <= MemRData_i;
                if (last_word) tags[set_idx] <= tag_in;
            end
            if (write_ack && hit) begin
                lines[set_idx][word_idx] <= merge_bytes(lines[set_idx][word_idx], WData_i, ByteEn_i);
            end
        end
    end

    always_comb begin
        state_next  = state;
        RData_o     = lines[set_idx][word_idx];
        Stall_o     = 1'b0;
        MemReq_o    = 1'b0;
        MemWE_o     = 1'b0;
        MemAddr_o   = '0;
        MemWData_o  = '0;
        MemByteEn_o = '0;
        case (state)
            IDLE: begin
                if (Req_i) begin
                    if (WE_i) begin
                        Stall_o    = 1'b1;
                        state_next = WRITE;
                    end else if (!hit) begin
                        Stall_o    = 1'b1;
                        state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                Stall_o   = 1'b1;
                MemReq_o  = 1'b1;
                MemAddr_o = {tag_in, set_idx, cnt, 2'b00};
                if (MemAck_i && last_word) state_next = IDLE;
            end
            WRITE: begin
                // Stall drops in the ack cycle so the pipeline advances on that edge
                Stall_o     = ~MemAck_i;
                MemReq_o    = 1'b1;
                MemWE_o     = 1'b1;
                MemAddr_o   = {Addr_i[ADDR_WIDTH-1:2], 2'b00};
                MemWData_o  = WData_i;
                MemByteEn_o = ByteEn_i;
                if (MemAck_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
